ray_scheduler: RTL and testbench
================================

# ray_scheduler

Sequences rays into the ray/triangle intersection pipeline that feeds the closest-hit accumulator. Pops one ray from the ray FIFO, then issues one entry per triangle (IDs 0..num_tri-1) into the intersection input FIFO, honouring backpressure. Triangle ID 0 marks the start of each ray, which is the boundary the accumulator uses to emit the previous ray's closest hit. Also keeps a running count of completed rays for the frame controller.

## Interface
Parameters:
- D_BITS, 32, width of each signed Q fixed-point ray component
- M_BITS, 12, triangle ID width
- C_BITS, 16, width of ray_count

Ports:
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- ray_empty  in  1  ray FIFO empty; ray_origin/ray_dir valid whenever low (first-word-fall-through)
- ray_rd_en  out  1  ray FIFO pop, combinational
- ray_origin  in  signed D_BITS ×3  ray origin [2:0]
- ray_dir  in  signed D_BITS ×3  ray direction [2:0]
- num_tri  in  M_BITS  triangles per ray, sampled at ray pop
- tri_full  in  1  intersection FIFO full
- tri_wr_en  out  1  intersection FIFO push, combinational
- tri_origin  out  signed D_BITS ×3  registered copy of current ray origin
- tri_dir  out  signed D_BITS ×3  registered copy of current ray direction
- tri_ID  out  M_BITS  registered triangle index of the current entry
- tri_flush  out  1  registered; marks a flush sentinel entry
- flush_req  in  1  level request to push a flush sentinel
- busy  out  1  high in any state other than IDLE
- ray_count  out  C_BITS  rays fully issued since reset

## Operation
- States: IDLE, ISSUE, FLUSH.
- IDLE: ray_rd_en = !ray_empty. On that edge, latch ray_origin/ray_dir into tri_origin/tri_dir, latch n = num_tri, clear tri_ID to 0, clear tri_flush, go to ISSUE.
- num_tri == 0: the ray is still popped. Go straight back to IDLE, issue no entries, and increment ray_count.
- ISSUE: tri_wr_en = !tri_full. On each accepted write:
  - if tri_ID == n-1, go to IDLE and increment ray_count;
  - otherwise tri_ID <= tri_ID+1.
- tri_full high: hold the state and all tri_* registers, with tri_wr_en low.
- num_tri changes mid-ray have no effect; only the latched n is used.
- tri_ID never wraps: n ≤ 2^M_BITS-1, so the maximum ID is 2^M_BITS-2.
- ray_count is modulo 2^C_BITS and wraps silently.
- Priority in IDLE: an available ray beats a flush request.
- Reset values: state IDLE, tri_origin/tri_dir/tri_ID 0, tri_flush 0, ray_count 0, busy 0.
- Combinational outputs ray_rd_en and tri_wr_en are forced 0 while reset is high.
- Reset mid-ray abandons the remaining entries. Entries already written stay in the FIFO. ray_count is not incremented for the abandoned ray.

## Timing
- Ray pop to first tri_wr_en opportunity: 1 cycle.
- With no backpressure, a ray occupies num_tri+1 cycles (1 pop + num_tri writes). Back-to-back rays have no extra bubble.
- tri_* data is registered and stable for the entire cycle tri_wr_en is high.
- ray_count updates on the edge that accepts the last entry and is visible the next cycle.
- busy is a registered state decode, so it rises the cycle after the pop.

## Configuration
- SCHED_FLUSH_EN defined:
  - An internal pending flag is set on every ray pop and cleared when a sentinel is accepted.
  - In IDLE with ray_empty high, flush_req high and pending set, go to FLUSH.
  - FLUSH drives tri_ID 0, tri_flush 1, tri_origin/tri_dir 0, and tri_wr_en = !tri_full.
  - On acceptance, clear pending and return to IDLE. ray_count is unchanged.
  - Effect: the accumulator emits the last ray's result without waiting for another ray.
- SCHED_FLUSH_EN undefined:
  - flush_req is ignored, tri_flush is constant 0, the FLUSH state and pending flag are absent.
  - The last ray's result is emitted only when the next ray arrives.

## Test plan
- Reset, num_tri=4, one ray (origin 1,2,3; dir 4,5,6), tri_full=0:
  - ray_rd_en pulses once;
  - then 4 consecutive writes with tri_ID 0,1,2,3 and unchanged origin/dir;
  - ray_count=1; busy low 1 cycle after the last write.
- Three rays queued, num_tri=2:
  - 9 cycles from the first pop to ray_count=3;
  - IDs 0,1,0,1,0,1 with no gaps beyond one pop cycle per ray.
- num_tri=5, tri_full held high 3 cycles after ID 1 is written:
  - tri_wr_en low and tri_ID stays 2 for exactly 3 cycles;
  - then IDs 2,3,4; no ID duplicated or skipped.
- num_tri=0, two rays:
  - both popped, no tri_wr_en, ray_count=2.
- Reset asserted after ID 2 of num_tri=8:
  - next cycle: tri_wr_en 0, tri_ID 0, ray_count 0, state IDLE;
  - the next ray restarts at ID 0.
- With SCHED_FLUSH_EN, one ray (num_tri=2), then flush_req=1 with ray FIFO empty:
  - exactly one sentinel (tri_ID 0, tri_flush 1, data 0);
  - a second flush_req produces nothing.
  - Without the macro, the same stimulus gives no sentinel.

Source files
------------

// File: rtl/ray_scheduler.sv
// ray_scheduler
// Pops one ray from the ray FIFO and then writes one intersection entry per
// triangle (IDs 0..n-1) into the intersection FIFO, honouring backpressure.
// Keeps a running count of fully issued rays.
//
// Optional feature: define SCHED_FLUSH_EN to enable flush sentinel entries,
// which let the accumulator emit the last ray's result without waiting for
// another ray to arrive.
//
// state | meaning
// IDLE  | waiting for a ray (or, with SCHED_FLUSH_EN, a flush request)
// ISSUE | writing triangle entries 0..n-1 for the current ray
// FLUSH | writing one flush sentinel entry (SCHED_FLUSH_EN only)
module ray_scheduler #(
    parameter int D_BITS = 32,
    parameter int M_BITS = 12,
    parameter int C_BITS = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     ray_empty,
    output logic                     ray_rd_en,
    input  logic signed [D_BITS-1:0] ray_origin [3],
    input  logic signed [D_BITS-1:0] ray_dir    [3],
    input  logic        [M_BITS-1:0] num_tri,
    input  logic                     tri_full,
    output logic                     tri_wr_en,
    output logic signed [D_BITS-1:0] tri_origin [3],
    output logic signed [D_BITS-1:0] tri_dir    [3],
    output logic        [M_BITS-1:0] tri_ID,
    output logic                     tri_flush,
    input  logic                     flush_req,
    output logic                     busy,
    output logic        [C_BITS-1:0] ray_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
`ifdef SCHED_FLUSH_EN
        FLUSH = 2'd2,
`endif
        ISSUE = 2'd1
    } state_t;

    localparam logic [M_BITS-1:0] ID_ONE    = M_BITS'(1);
    localparam logic [C_BITS-1:0] COUNT_ONE = C_BITS'(1);

    state_t            state;
    state_t            state_next;
    logic [M_BITS-1:0] n_lat;
    logic              last_entry;
    logic              issue_accept;
    logic              ray_done;

    // Current entry is the last of the ray; n_lat is nonzero whenever in ISSUE.
    assign last_entry   = (tri_ID == (n_lat - ID_ONE));
    assign issue_accept = (state == ISSUE) && tri_wr_en;
    // A zero-triangle ray completes at its pop; otherwise on its last write.
    assign ray_done     = (ray_rd_en && (num_tri == '0)) || (issue_accept && last_entry);

`ifdef SCHED_FLUSH_EN
    logic pending;
    logic flush_start;
    logic flush_accept;

    assign flush_accept = (state == FLUSH) && tri_wr_en;
`else
    logic unused_flush_req;

    assign unused_flush_req = flush_req;
    assign tri_flush        = 1'b0;
`endif

    // Next-state decode and the combinational FIFO handshakes.
    always_comb begin
        state_next = state;
        ray_rd_en  = 1'b0;
        tri_wr_en  = 1'b0;
`ifdef SCHED_FLUSH_EN
        flush_start = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (!ray_empty) begin
                    ray_rd_en = 1'b1;
                    if (num_tri != '0) begin
                        state_next = ISSUE;
                    end
                end
`ifdef SCHED_FLUSH_EN
                else if (flush_req && pending) begin
                    flush_start = 1'b1;
                    state_next  = FLUSH;
                end
`endif
            end
            ISSUE: begin
                if (!tri_full) begin
                    tri_wr_en = 1'b1;
                    if (last_entry) begin
                        state_next = IDLE;
                    end
                end
            end
`ifdef SCHED_FLUSH_EN
            FLUSH: begin
                if (!tri_full) begin
                    tri_wr_en  = 1'b1;
                    state_next = IDLE;
                end
            end
`endif
            default: state_next = IDLE;
        endcase
        if (reset) begin
            ray_rd_en = 1'b0;
            tri_wr_en = 1'b0;
`ifdef SCHED_FLUSH_EN
            flush_start = 1'b0;
`endif
        end
    end

    // State register; busy is a registered decode of the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Entry data: latch the ray at pop, step the triangle ID on each accepted write.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                tri_origin[i] <= '0;
                tri_dir[i]    <= '0;
            end
            tri_ID <= '0;
            n_lat  <= '0;
        end else if (ray_rd_en) begin
            for (int i = 0; i < 3; i++) begin
                tri_origin[i] <= ray_origin[i];
                tri_dir[i]    <= ray_dir[i];
            end
            tri_ID <= '0;
            n_lat  <= num_tri;
        end else if (issue_accept && !last_entry) begin
            tri_ID <= tri_ID + ID_ONE;
        end
`ifdef SCHED_FLUSH_EN
        else if (flush_start) begin
            for (int i = 0; i < 3; i++) begin
                tri_origin[i] <= '0;
                tri_dir[i]    <= '0;
            end
            tri_ID <= '0;
        end
`endif
    end

`ifdef SCHED_FLUSH_EN
    // Sentinel marker and the flag that a ray has been issued since the last sentinel.
    always_ff @(posedge clock) begin
        if (reset) begin
            tri_flush <= 1'b0;
            pending   <= 1'b0;
        end else begin
            if (ray_rd_en) begin
                tri_flush <= 1'b0;
                pending   <= 1'b1;
            end else if (flush_start) begin
                tri_flush <= 1'b1;
            end
            if (flush_accept) begin
                pending <= 1'b0;
            end
        end
    end
`endif

    // Completed-ray counter, wraps modulo 2^C_BITS.
    always_ff @(posedge clock) begin
        if (reset) begin
            ray_count <= '0;
        end else if (ray_done) begin
            ray_count <= ray_count + COUNT_ONE;
        end
    end

endmodule

// File: tb/tb_ray_scheduler.sv
// Testbench for ray_scheduler: directed stimulus, a transaction-level model
// of the expected entry stream, and a per-cycle compare against the DUT.
module tb_ray_scheduler;

    localparam int D_BITS = 32;
    localparam int M_BITS = 12;
    localparam int C_BITS = 16;

    typedef struct packed {
        logic [2:0][31:0] o;
        logic [2:0][31:0] d;
    } ray_t;

    typedef struct packed {
        logic [11:0]      id;
        logic [2:0][31:0] o;
        logic [2:0][31:0] d;
        logic             flush;
        logic             last;
    } ent_t;

    logic                     clock;
    logic                     reset;
    logic                     ray_empty;
    logic                     ray_rd_en;
    logic signed [D_BITS-1:0] ray_origin [3];
    logic signed [D_BITS-1:0] ray_dir    [3];
    logic        [M_BITS-1:0] num_tri;
    logic                     tri_full;
    logic                     tri_wr_en;
    logic signed [D_BITS-1:0] tri_origin [3];
    logic signed [D_BITS-1:0] tri_dir    [3];
    logic        [M_BITS-1:0] tri_ID;
    logic                     tri_flush;
    logic                     flush_req;
    logic                     busy;
    logic        [C_BITS-1:0] ray_count;

    ray_scheduler #(.D_BITS(D_BITS), .M_BITS(M_BITS), .C_BITS(C_BITS)) dut (
        .clock(clock), .reset(reset), .ray_empty(ray_empty), .ray_rd_en(ray_rd_en),
        .ray_origin(ray_origin), .ray_dir(ray_dir), .num_tri(num_tri),
        .tri_full(tri_full), .tri_wr_en(tri_wr_en), .tri_origin(tri_origin),
        .tri_dir(tri_dir), .tri_ID(tri_ID), .tri_flush(tri_flush),
        .flush_req(flush_req), .busy(busy), .ray_count(ray_count)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    ray_t        fifo[$];
    ent_t        exp_q[$];
    logic [15:0] m_count = '0;
    bit          m_busy  = 0;
    bit          m_pending = 0;
    bit          fresh = 1;
    bit          armed = 0;
    int          first_pop = -1;

    int          id_log[$];
    int          rd_seen   = 0;
    int          sent_seen = 0;

`ifdef SCHED_FLUSH_EN
    localparam int FLUSH_ON = 1;
`else
    localparam int FLUSH_ON = 0;
`endif

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial forever begin
        @(posedge clock);
        cyc++;
    end

    // Model and per-cycle compare: check at the falling edge, then apply what
    // the coming rising edge does to the expected stream.
    initial forever begin
        bit   exp_rd;
        bit   exp_wr;
        bit   do_reset;
        bit   do_flush;
        int   n;
        ray_t r;
        ent_t e;
        @(negedge clock);
        if (tri_wr_en === 1'b1) begin
            id_log.push_back(int'(tri_ID));
            if (tri_flush === 1'b1) sent_seen++;
        end
        if (ray_rd_en === 1'b1) rd_seen++;

        exp_rd = !reset && (fifo.size() != 0) && (exp_q.size() == 0);
        exp_wr = !reset && (exp_q.size() != 0) && !tri_full;
        do_flush = 0;
        if (FLUSH_ON != 0)
            do_flush = !reset && (fifo.size() == 0) && (exp_q.size() == 0) && flush_req && m_pending;

        if (armed) begin
            chk("ray_rd_en", ray_rd_en, exp_rd);
            chk("tri_wr_en", tri_wr_en, exp_wr);
            chk("ray_count", ray_count, m_count);
            chk("busy", busy, m_busy);
            if (!reset && exp_q.size() != 0) begin
                e = exp_q[0];
                chk("tri_ID", tri_ID, e.id);
                chk("tri_flush", tri_flush, e.flush);
                for (int i = 0; i < 3; i++) begin
                    chk("tri_origin", {32'b0, tri_origin[i]}, e.o[i]);
                    chk("tri_dir", {32'b0, tri_dir[i]}, e.d[i]);
                end
            end
            if (fresh) begin
                chk("reset_tri_ID", tri_ID, 0);
                chk("reset_tri_flush", tri_flush, 0);
                chk("reset_tri_origin", {32'b0, tri_origin[0]}, 0);
                chk("reset_tri_dir", {32'b0, tri_dir[2]}, 0);
            end
            if (FLUSH_ON == 0) chk("tri_flush_const", tri_flush, 0);
        end
        do_reset = reset;
        n = int'(num_tri);

        @(posedge clock);
        #2;
        if (do_reset) begin
            exp_q.delete();
            m_count   = '0;
            m_pending = 0;
            m_busy    = 0;
            fresh     = 1;
            armed     = 1;
        end else begin
            if (exp_wr) begin
                e = exp_q.pop_front();
                if (e.last) m_count++;
                if (e.flush) m_pending = 0;
            end
            if (exp_rd) begin
                r = fifo.pop_front();
                m_pending = 1;
                fresh = 0;
                if (first_pop < 0) first_pop = cyc;
                if (n == 0) m_count++;
                for (int i = 0; i < n; i++) begin
                    e.id    = 12'(i);
                    e.o     = r.o;
                    e.d     = r.d;
                    e.flush = 1'b0;
                    e.last  = (i == n - 1);
                    exp_q.push_back(e);
                end
            end
            if (do_flush) begin
                e.id    = '0;
                e.o     = '0;
                e.d     = '0;
                e.flush = 1'b1;
                e.last  = 1'b0;
                exp_q.push_back(e);
                fresh = 0;
            end
            m_busy = (exp_q.size() != 0);
        end
        ray_empty = (fifo.size() == 0);
        if (fifo.size() != 0) begin
            for (int i = 0; i < 3; i++) begin
                ray_origin[i] = fifo[0].o[i];
                ray_dir[i]    = fifo[0].d[i];
            end
        end
    end

    task automatic push_ray(input int o0, input int o1, input int o2,
                            input int d0, input int d1, input int d2);
        ray_t r;
        r.o[0] = o0; r.o[1] = o1; r.o[2] = o2;
        r.d[0] = d0; r.d[1] = d1; r.d[2] = d2;
        fifo.push_back(r);
    endtask

    task automatic do_reset_cycle();
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        id_log.delete();
        rd_seen   = 0;
        sent_seen = 0;
        first_pop = -1;
    endtask

    task automatic wait_idle(input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(posedge clock); #3;
            if (fifo.size() == 0 && exp_q.size() == 0 && !m_busy) break;
        end
        chk("wait_idle_timeout", (k >= budget), 0);
        @(negedge clock); #1;
    endtask

    task automatic wait_ids(input int cnt, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clock); #1;
            if (id_log.size() >= cnt) break;
        end
        chk("wait_ids_timeout", (k >= budget), 0);
    endtask

    task automatic check_ids(input string nm, input int exp_ids[$]);
        chk({nm, "_len"}, id_log.size(), exp_ids.size());
        for (int i = 0; i < exp_ids.size() && i < id_log.size(); i++)
            chk(nm, id_log[i], exp_ids[i]);
    endtask

    initial begin
        int hold;
        int k;
        reset     = 1'b1;
        tri_full  = 1'b0;
        flush_req = 1'b0;
        num_tri   = '0;
        ray_empty = 1'b1;
        for (int i = 0; i < 3; i++) begin
            ray_origin[i] = '0;
            ray_dir[i]    = '0;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock); #1;
        chk("rst_ray_count", ray_count, 0);
        chk("rst_busy", busy, 0);

        // One ray, four triangles.
        id_log.delete(); rd_seen = 0;
        @(posedge clock); #1;
        num_tri = 12'd4;
        push_ray(1, 2, 3, 4, 5, 6);
        wait_idle(50);
        check_ids("t1_ids", '{0, 1, 2, 3});
        chk("t1_count", ray_count, 1);
        chk("t1_pops", rd_seen, 1);
        chk("t1_busy", busy, 0);

        // Three rays back to back, two triangles each.
        do_reset_cycle();
        num_tri = 12'd2;
        push_ray(10, -7, 30, 1, 0, -1);
        push_ray(11, 21, 31, 2, 2, 2);
        push_ray(-12, 22, 32, 3, 3, 3);
        for (k = 0; k < 40; k++) begin
            @(negedge clock); #1;
            if (ray_count == 16'd3) break;
        end
        chk("t2_timeout", (k >= 40), 0);
        chk("t2_cycles", cyc - first_pop + 1, 9);
        check_ids("t2_ids", '{0, 1, 0, 1, 0, 1});

        // Backpressure for three cycles after ID 1.
        do_reset_cycle();
        num_tri = 12'd5;
        push_ray(7, 8, 9, -1, -2, -3);
        wait_ids(2, 20);
        @(posedge clock); #1;
        tri_full = 1'b1;
        hold = 0;
        repeat (3) begin
            @(negedge clock); #1;
            if (tri_wr_en == 1'b0 && tri_ID == 12'd2) hold++;
        end
        @(posedge clock); #1;
        tri_full = 1'b0;
        wait_idle(40);
        chk("t3_hold", hold, 3);
        check_ids("t3_ids", '{0, 1, 2, 3, 4});
        chk("t3_count", ray_count, 1);

        // Zero-triangle rays.
        do_reset_cycle();
        num_tri = 12'd0;
        push_ray(1, 1, 1, 1, 1, 1);
        push_ray(2, 2, 2, 2, 2, 2);
        wait_idle(20);
        chk("t4_pops", rd_seen, 2);
        chk("t4_writes", id_log.size(), 0);
        chk("t4_count", ray_count, 2);

        // Reset mid-ray.
        do_reset_cycle();
        num_tri = 12'd8;
        push_ray(5, 6, 7, 8, 9, 10);
        wait_ids(3, 20);
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock); #1;
        chk("t5_wr_en", tri_wr_en, 0);
        chk("t5_tri_ID", tri_ID, 0);
        chk("t5_count", ray_count, 0);
        chk("t5_busy", busy, 0);
        id_log.delete();
        num_tri = 12'd3;
        push_ray(4, 4, 4, 5, 5, 5);
        wait_idle(30);
        check_ids("t5_ids", '{0, 1, 2});
        chk("t5_count_after", ray_count, 1);

        // Flush sentinel handling.
        do_reset_cycle();
        num_tri = 12'd2;
        push_ray(3, 3, 3, 6, 6, 6);
        wait_idle(20);
        id_log.delete(); sent_seen = 0;
        flush_req = 1'b1;
        repeat (4) @(posedge clock);
        #1 flush_req = 1'b0;
        repeat (2) @(posedge clock);
        #1 flush_req = 1'b1;
        repeat (4) @(posedge clock);
        #1 flush_req = 1'b0;
        wait_idle(20);
        chk("t6_sentinels", sent_seen, FLUSH_ON);
        chk("t6_writes", id_log.size(), FLUSH_ON);
        chk("t6_count", ray_count, 1);
        flush_req = 1'b1;
        push_ray(9, 9, 9, 1, 1, 1);
        wait_idle(20);
        repeat (3) @(posedge clock);
        #1 flush_req = 1'b0;
        wait_idle(20);
        chk("t6_sentinels_total", sent_seen, 2 * FLUSH_ON);
        chk("t6_count_total", ray_count, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad + 1);
        $fatal(1, "watchdog");
    end

endmodule
